alm_config_loader: RTL and testbench

//  Hardware bitstream loader for the ALM configuration chain. Takes bitstream words on a

---
 rtl/alm_config_loader_if.sv | 18 +
 rtl/alm_config_loader.sv | 191 +++++++++++++++++++
 tb/tb_alm_config_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alm_config_loader_if.sv
// ---------------------------------------------------------------------------
// alm_config_loader_if
// Bitstream word stream feeding the ALM configuration loader.
//   word_data   WORD_W  bitstream word, bit WORD_W-1 is shifted first
//   word_valid  1       word_data valid (driven by the source)
//   word_ready  1       loader accepts the word this cycle
// Modports: master = word source, slave = loader.
// ---------------------------------------------------------------------------
interface alm_config_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/alm_config_loader.sv
// ---------------------------------------------------------------------------
// alm_config_loader
// Hardware bitstream loader for an ALM configuration chain. Words arriving on
// a valid/ready stream are shifted MSB-first, one bit per clock, into the
// chain through config_in/config_en. The chain's config_clk is clk.
//
// Ports
//   clk            system clock, also config_clk of the chain
//   clear_async_n  asynchronous active-low reset
//   start          begin a load (sampled in IDLE or DONE only)
//   abort          cancel a load in progress (wins over start)
//   word_if        slave side of the word stream (word_data/valid/ready)
//   config_in      serial config bit to the chain
//   config_en      chain shift enable
//   config_out     serial output of the last chain element
//   busy           load (or readback) in progress
//   done           load completed, held until the next start
//   error          readback CRC mismatch (always 0 without readback)
//
// Optional feature: define CONFIG_READBACK_EN to add a READBACK pass that
// rotates the chain once through config_out -> config_in and compares a CRC
// of what comes out against the CRC of what was loaded.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset or abort
// S_FETCH   | word_ready high, waiting for the next bitstream word
// S_SHIFT   | shifting the held word into the chain, one bit per clock
// S_READBACK| rotating the chain once, accumulating the readback CRC
// S_DONE    | load finished, done high until the next start
// ---------------------------------------------------------------------------
module alm_config_loader #(
  parameter int CHAIN_LEN = 87,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 7
) (
  input  logic                clk,
  input  logic                clear_async_n,
  input  logic                start,
  input  logic                abort,
  alm_config_loader_if.slave  word_if,
  output logic                config_in,
  output logic                config_en,
  input  logic                config_out,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int BC_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_READBACK,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  bits_left;
  logic [BC_W-1:0]   word_left;
  logic [15:0]       crc_ld;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge clear_async_n) begin
    if (!clear_async_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    word_if.word_ready = 1'b0;
    config_en          = 1'b0;
    config_in          = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        word_if.word_ready = 1'b1;
        busy               = 1'b1;
        if (abort)                   state_nxt = S_IDLE;
        else if (word_if.word_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        config_en = 1'b1;
        config_in = sreg[WORD_W-1];
        busy      = 1'b1;
        if (abort) state_nxt = S_IDLE;
        else if (bits_left == CNT_W'(1)) begin
`ifdef CONFIG_READBACK_EN
          state_nxt = S_READBACK;
`else
          state_nxt = S_DONE;
`endif
        end
        else if (word_left == BC_W'(1)) state_nxt = S_FETCH;
      end
`ifdef CONFIG_READBACK_EN
      S_READBACK: begin
        // Feeding the chain's own output back in rotates it; after CHAIN_LEN
        // shifts the loaded image is back in place.
        config_en = 1'b1;
        config_in = config_out;
        busy      = 1'b1;
        if (abort)                       state_nxt = S_IDLE;
        else if (bits_left == CNT_W'(1)) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef CONFIG_READBACK_EN
  logic [15:0] crc_rb;
  logic [15:0] crc_rb_nxt;
  logic        error_q;

  assign crc_rb_nxt = crc_step(crc_rb, config_out);
  assign error      = error_q;
`else
  // config_out only matters to the readback pass.
  logic unused_config_out;
  assign unused_config_out = config_out;
  assign error             = 1'b0;
`endif

  always_ff @(posedge clk or negedge clear_async_n) begin
    if (!clear_async_n) begin
      sreg      <= '0;
      bits_left <= '0;
      word_left <= '0;
      crc_ld    <= 16'hFFFF;
`ifdef CONFIG_READBACK_EN
      crc_rb    <= 16'hFFFF;
      error_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            bits_left <= CNT_W'(CHAIN_LEN);
            crc_ld    <= 16'hFFFF;
`ifdef CONFIG_READBACK_EN
            crc_rb    <= 16'hFFFF;
            error_q   <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (word_if.word_valid) begin
            sreg      <= word_if.word_data;
            word_left <= BC_W'(WORD_W);
          end
        end
        S_SHIFT: begin
          sreg      <= sreg << 1;
          word_left <= word_left - BC_W'(1);
          crc_ld    <= crc_step(crc_ld, sreg[WORD_W-1]);
`ifdef CONFIG_READBACK_EN
          // The same counter times the readback pass.
          if (bits_left == CNT_W'(1)) bits_left <= CNT_W'(CHAIN_LEN);
          else                        bits_left <= bits_left - CNT_W'(1);
`else
          bits_left <= bits_left - CNT_W'(1);
`endif
        end
`ifdef CONFIG_READBACK_EN
        S_READBACK: begin
          crc_rb    <= crc_rb_nxt;
          bits_left <= bits_left - CNT_W'(1);
          if (bits_left == CNT_W'(1)) error_q <= (crc_rb_nxt != crc_ld);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alm_config_loader.sv
// ---------------------------------------------------------------------------
// tb_alm_config_loader
// Directed bench for alm_config_loader: an 87-flop chain model driven by
// config_in/config_en, a word source on the stream interface, and a reference
// image computed from the bitstream words. Builds with or without
// CONFIG_READBACK_EN.
// ---------------------------------------------------------------------------
module tb_alm_config_loader;

`ifdef CONFIG_READBACK_EN
  localparam int EN_EXP   = 174;
  localparam int BUSY_EXP = 185;
`else
  localparam int EN_EXP   = 87;
  localparam int BUSY_EXP = 98;
`endif

  logic clk = 1'b0;
  logic clear_async_n;
  logic start, abort;
  logic config_in, config_en, config_out, busy, done, error;

  alm_config_loader_if #(.WORD_W(8)) wif ();

  alm_config_loader #(.CHAIN_LEN(87), .WORD_W(8), .CNT_W(7)) dut (
    .clk           (clk),
    .clear_async_n (clear_async_n),
    .start         (start),
    .abort         (abort),
    .word_if       (wif.slave),
    .config_in     (config_in),
    .config_en     (config_en),
    .config_out    (config_out),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  logic [7:0] words [11] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69,
                             8'hC3, 8'h5A, 8'hE1, 8'h1E, 8'b1010_1011};
  logic [86:0] exp_img;

  // chain model: config_in enters flop 0, config_out is flop 86
  logic [86:0] chain = '0;
  logic [86:0] inj   = '0;
  assign config_out = chain[86];
  always @(posedge clk) begin
    if (config_en) chain <= {chain[85:0], config_in} ^ inj;
    else           chain <= chain ^ inj;
  end

  // word source and monitors
  logic src_clr, src_en, gap_en;
  int   wi, hs_count, en_count, busy_count, gap_cnt, wait_cnt, bad_en;
  logic [6:0] tail;

  assign wif.word_data  = (wi < 11) ? words[wi] : 8'h00;
  assign wif.word_valid = src_en && (wi < 11) && !(gap_en && wi == 5 && gap_cnt < 5);

  always @(posedge clk) begin
    if (src_clr) begin
      wi <= 0; hs_count <= 0; en_count <= 0; busy_count <= 0;
      gap_cnt <= 0; wait_cnt <= 0; bad_en <= 0; tail <= '0;
    end else begin
      if (wif.word_valid && wif.word_ready) begin
        wi       <= wi + 1;
        hs_count <= hs_count + 1;
      end
      if (config_en) begin
        en_count <= en_count + 1;
        if (en_count < 87) tail <= {tail[5:0], config_in};
      end
      if (busy) busy_count <= busy_count + 1;
      if (gap_en && wi == 5 && wif.word_ready && gap_cnt < 5) gap_cnt <= gap_cnt + 1;
      if (wif.word_ready && !wif.word_valid) wait_cnt <= wait_cnt + 1;
      if (wif.word_ready && config_en) bad_en <= bad_en + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    src_clr = 1'b1;
    @(negedge clk);
    src_clr = 1'b0;
    src_en  = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    check(tag, 128'(ok), 128'(1));
  endtask

  task automatic wait_en(input string tag, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (en_count == n) begin ok = 1'b1; break; end
    end
    check(tag, 128'(ok), 128'(1));
  endtask

  initial begin
    for (int i = 0; i < 87; i++) exp_img[86-i] = words[i/8][7-(i%8)];

    clear_async_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    src_clr = 1'b1; src_en = 1'b0; gap_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({wif.word_ready, config_in, config_en, busy, done, error}), 128'(0));
    clear_async_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 128'({wif.word_ready, config_en, busy, done, error}), 128'(0));

    // 1/2: full load with valid held high; a start pulse mid-load is ignored
    start_load();
    wait_en("t1_wait10", 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1_done_timeout");
    check("t1_en_cycles", 128'(en_count), 128'(EN_EXP));
    check("t1_handshakes", 128'(hs_count), 128'(11));
    check("t1_busy_cycles", 128'(busy_count), 128'(BUSY_EXP));
    check("t1_image", 128'(chain), 128'(exp_img));
    check("t1_done_busy", 128'({done, busy}), 128'(2'b10));
    check("t1_error", 128'(error), 128'(0));
    check("t2_last_bits", 128'(tail), 128'(7'b1010101));
    repeat (3) @(negedge clk);
    check("t1_done_held", 128'({done, busy}), 128'(2'b10));

    // 3: source stalls 5 cycles before word 6
    gap_en = 1'b1;
    start_load();
    wait_done("t3_done_timeout");
    check("t3_busy_cycles", 128'(busy_count), 128'(BUSY_EXP + 5));
    check("t3_wait_cycles", 128'(wait_cnt), 128'(5));
    check("t3_en_in_fetch", 128'(bad_en), 128'(0));
    check("t3_image", 128'(chain), 128'(exp_img));
    check("t3_en_cycles", 128'(en_count), 128'(EN_EXP));
    gap_en = 1'b0;

    // 4: abort after 40 bits, then a clean reload
    start_load();
    wait_en("t4_wait40", 40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_after_abort", 128'({wif.word_ready, config_en, busy, done}), 128'(0));
    start_load();
    wait_done("t4_done_timeout");
    check("t4_image", 128'(chain), 128'(exp_img));
    check("t4_en_cycles", 128'(en_count), 128'(EN_EXP));

    // 5: reset asserted after 20 bits, then a clean reload
    start_load();
    wait_en("t5_wait20", 20);
    #1 clear_async_n = 1'b0;
    #1 check("t5_reset_now", 128'({wif.word_ready, config_in, config_en, busy, done, error}), 128'(0));
    @(negedge clk);
    clear_async_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_idle", 128'({busy, done}), 128'(0));
    start_load();
    wait_done("t5_done_timeout");
    check("t5_image", 128'(chain), 128'(exp_img));
    check("t5_busy_cycles", 128'(busy_count), 128'(BUSY_EXP));

`ifdef CONFIG_READBACK_EN
    // 6: corrupt the chain during readback, then reload cleanly
    start_load();
    wait_en("t6_wait100", 100);
    inj = 87'(1) << 30;
    @(negedge clk);
    inj = '0;
    wait_done("t6_done_timeout");
    check("t6_error_set", 128'(error), 128'(1));
    start_load();
    check("t6_error_cleared", 128'(error), 128'(0));
    wait_done("t6b_done_timeout");
    check("t6_error_clean", 128'(error), 128'(0));
    check("t6_image", 128'(chain), 128'(exp_img));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
